// File: rtl/div_iter_hs_if.sv
// Operand/result handshake bundle for the iterative divider.
// master = issue side, slave = divider.
interface div_iter_hs_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [W-1:0] in_dividend;
    logic [W-1:0] in_divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_dz;
    logic         out_ovf;
    logic         busy;

    modport master (
        output in_valid, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dz, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dz, out_ovf, busy
    );
endinterface

// File: rtl/div_iter_hs.sv
// Iterative radix-2 restoring divider, signed/unsigned, with valid/ready handshake.
// Optional abort input enabled by defining DIV_FLUSH_EN.
module div_iter_hs #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef DIV_FLUSH_EN
    input  logic         flush,
`endif
    div_iter_hs_if.slave bus
);
    localparam int               CNT_W    = $clog2(W) + 1;
    localparam logic [W-1:0]     ZERO     = {W{1'b0}};
    localparam logic [W-1:0]     ONES     = {W{1'b1}};
    localparam logic [W-1:0]     MIN_VAL  = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [W-1:0] neg(input logic [W-1:0] v);
        return ZERO - v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [W:0]       rem_r;
    logic [W-1:0]     quo_r;
    logic [W-1:0]     div_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [W-1:0]     q_out_r;
    logic [W-1:0]     r_out_r;
    logic             dz_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic             flush_s;
    logic             accept_s;
    logic             dz_s;
    logic             ovf_s;
    logic [W-1:0]     dvd_abs_s;
    logic [W-1:0]     dvs_abs_s;
    logic [W:0]       shift_s;
    logic [W:0]       diff_s;

`ifdef DIV_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    assign bus.in_ready = (state_r == IDLE) & ~flush_s;
    assign accept_s     = bus.in_valid & bus.in_ready;
    assign dz_s         = (bus.in_divisor == ZERO);
    assign ovf_s        = bus.in_signed & (bus.in_dividend == MIN_VAL) & (bus.in_divisor == ONES);
    // abs(MIN) wraps back to MIN, which is the correct magnitude read as unsigned.
    assign dvd_abs_s    = (bus.in_signed & bus.in_dividend[W-1]) ? neg(bus.in_dividend) : bus.in_dividend;
    assign dvs_abs_s    = (bus.in_signed & bus.in_divisor[W-1])  ? neg(bus.in_divisor)  : bus.in_divisor;
    assign shift_s      = {rem_r[W-1:0], quo_r[W-1]};
    assign diff_s       = shift_s - {1'b0, div_r};

    assign bus.out_valid     = out_valid_r;
    assign bus.out_quotient  = q_out_r;
    assign bus.out_remainder = r_out_r;
    assign bus.out_dz        = dz_r;
    assign bus.out_ovf       = ovf_r;
    assign bus.busy          = (state_r != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (dz_s || ovf_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            FIX: state_nxt_s = DONE;
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (flush_s) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Datapath: operand capture, shift-subtract iterations, sign fix-up and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= CNT_ZERO;
            rem_r       <= {(W+1){1'b0}};
            quo_r       <= ZERO;
            div_r       <= ZERO;
            neg_q_r     <= 1'b0;
            neg_r_r     <= 1'b0;
            q_out_r     <= ZERO;
            r_out_r     <= ZERO;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (flush_s) begin
            out_valid_r <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rem_r   <= {(W+1){1'b0}};
                        quo_r   <= dvd_abs_s;
                        div_r   <= dvs_abs_s;
                        cnt_r   <= CNT_LOAD;
                        neg_q_r <= bus.in_signed & (bus.in_dividend[W-1] ^ bus.in_divisor[W-1]);
                        neg_r_r <= bus.in_signed & bus.in_dividend[W-1];
                        dz_r    <= dz_s;
                        ovf_r   <= ovf_s & ~dz_s;
                        if (dz_s) begin
                            q_out_r     <= ONES;
                            r_out_r     <= bus.in_dividend;
                            out_valid_r <= 1'b1;
                        end else if (ovf_s) begin
                            q_out_r     <= MIN_VAL;
                            r_out_r     <= ZERO;
                            out_valid_r <= 1'b1;
                        end else begin
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= diff_s[W] ? shift_s : diff_s;
                    quo_r <= {quo_r[W-2:0], ~diff_s[W]};
                    cnt_r <= cnt_r - CNT_ONE;
                end
                FIX: begin
                    q_out_r     <= neg_q_r ? neg(quo_r) : quo_r;
                    r_out_r     <= neg_r_r ? neg(rem_r[W-1:0]) : rem_r[W-1:0];
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter_hs.sv
// Directed table-driven bench for div_iter_hs at W=8, plus backpressure,
// mid-operation reset and (with DIV_FLUSH_EN) flush sequences.
module tb_div_iter_hs;
    localparam int W = 8;

    logic clk;
    logic rst_n;
`ifdef DIV_FLUSH_EN
    logic flush;
`endif

    div_iter_hs_if #(.W(W)) bus_if ();

    div_iter_hs #(.W(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef DIV_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       sgn;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands once in_ready is up; returns 1 ns after the accept edge.
    task automatic start_op(input logic s, input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        while (!bus_if.in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_wait", {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_signed   = s;
        bus_if.in_dividend = a;
        bus_if.in_divisor  = b;
        bus_if.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus_if.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ovf, output int lat);
        start_op(s, a, b);
        wait_valid(lat);
        q   = bus_if.out_quotient;
        r   = bus_if.out_remainder;
        dz  = bus_if.out_dz;
        ovf = bus_if.out_ovf;
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
    endtask

    vec_t       vecs [15];
    logic [7:0] q, r;
    logic       dz, ovf;
    int         lat;
    logic       seen;

    initial begin
        vecs[0]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 10};
        vecs[1]  = '{1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 10};
        vecs[2]  = '{1'b1, 8'd7,   8'hFE,  8'hFD,  8'd1,   1'b0, 1'b0, 10};
        vecs[3]  = '{1'b0, 8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1'b0, 1};
        vecs[4]  = '{1'b1, 8'd37,  8'd0,   8'hFF,  8'd37,  1'b1, 1'b0, 1};
        vecs[5]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 1'b1, 1};
        vecs[6]  = '{1'b0, 8'h80,  8'hFF,  8'd0,   8'h80,  1'b0, 1'b0, 10};
        vecs[7]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 10};
        vecs[8]  = '{1'b0, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 1'b0, 10};
        vecs[9]  = '{1'b1, 8'h80,  8'd2,   8'hC0,  8'd0,   1'b0, 1'b0, 10};
        vecs[10] = '{1'b1, 8'h80,  8'd3,   8'hD6,  8'hFE,  1'b0, 1'b0, 10};
        vecs[11] = '{1'b1, 8'hF9,  8'hFE,  8'd3,   8'hFF,  1'b0, 1'b0, 10};
        vecs[12] = '{1'b0, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0, 1'b0, 10};
        vecs[13] = '{1'b1, 8'h80,  8'h80,  8'd1,   8'd0,   1'b0, 1'b0, 10};
        vecs[14] = '{1'b0, 8'd100, 8'd200, 8'd0,   8'd100, 1'b0, 1'b0, 10};

        rst_n              = 1'b1;
        bus_if.in_valid    = 1'b0;
        bus_if.in_signed   = 1'b0;
        bus_if.in_dividend = 8'd0;
        bus_if.in_divisor  = 8'd0;
        bus_if.out_ready   = 1'b0;
`ifdef DIV_FLUSH_EN
        flush = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, bus_if.busy},      32'd0);
        chk("rst_q",         {24'd0, bus_if.out_quotient},  32'd0);
        chk("rst_r",         {24'd0, bus_if.out_remainder}, 32'd0);
        chk("rst_dz",        {31'd0, bus_if.out_dz},    32'd0);
        chk("rst_ovf",       {31'd0, bus_if.out_ovf},   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, ovf, lat);
            chk($sformatf("v%0d_q", i),   {24'd0, q},   {24'd0, vecs[i].q});
            chk($sformatf("v%0d_r", i),   {24'd0, r},   {24'd0, vecs[i].r});
            chk($sformatf("v%0d_dz", i),  {31'd0, dz},  {31'd0, vecs[i].dz});
            chk($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
        end

        // Output backpressure: result held, no new accept until consumed.
        start_op(1'b0, 8'd200, 8'd7);
        wait_valid(lat);
        chk("bp_lat", lat, 10);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", c), {31'd0, bus_if.out_valid},    32'd1);
            chk($sformatf("bp%0d_q", c),     {24'd0, bus_if.out_quotient}, 32'd28);
            chk($sformatf("bp%0d_r", c),     {24'd0, bus_if.out_remainder}, 32'd4);
            chk($sformatf("bp%0d_ready", c), {31'd0, bus_if.in_ready},     32'd0);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        chk("bp_rel_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("bp_rel_ready", {31'd0, bus_if.in_ready},  32'd1);
        do_op(1'b0, 8'd9, 8'd3, q, r, dz, ovf, lat);
        chk("bp_next_q", {24'd0, q}, 32'd3);
        chk("bp_next_r", {24'd0, r}, 32'd0);

        // Asynchronous reset during the 4th CALC cycle discards the operation.
        start_op(1'b0, 8'd100, 8'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_pre", {31'd0, bus_if.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {31'd0, bus_if.busy},      32'd0);
        chk("mid_rst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            seen = seen | bus_if.out_valid;
        end
        chk("mid_rst_no_valid", {31'd0, seen}, 32'd0);
        do_op(1'b0, 8'd9, 8'd3, q, r, dz, ovf, lat);
        chk("mid_next_q",   {24'd0, q}, 32'd3);
        chk("mid_next_r",   {24'd0, r}, 32'd0);
        chk("mid_next_lat", lat, 10);

`ifdef DIV_FLUSH_EN
        // Flush in CALC returns to IDLE with no result.
        start_op(1'b0, 8'd200, 8'd7);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fl_busy",  {31'd0, bus_if.busy},      32'd0);
        chk("fl_valid", {31'd0, bus_if.out_valid}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            seen = seen | bus_if.out_valid;
        end
        chk("fl_no_valid", {31'd0, seen}, 32'd0);
        // Flush beats a same-cycle accept.
        bus_if.in_signed   = 1'b0;
        bus_if.in_dividend = 8'd50;
        bus_if.in_divisor  = 8'd5;
        bus_if.in_valid    = 1'b1;
        flush              = 1'b1;
        #1;
        chk("fl_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        flush           = 1'b0;
        chk("fl_no_accept", {31'd0, bus_if.busy}, 32'd0);
        do_op(1'b0, 8'd50, 8'd5, q, r, dz, ovf, lat);
        chk("fl_next_q", {24'd0, q}, 32'd10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
